// File: rtl/life_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : life_sequencer
// Purpose  : Loads, steps and scans out a toroidal Life cell grid from commands.
// Revision : 1.0
// ============================================================================
module life_sequencer #(
    parameter int WIDTH  = 17,
    parameter int HEIGHT = 17,
    parameter int SETTLE = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [15:0]               cmd_arg_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic                      load_bit_i,
    output logic                      grid_load_o,
    output logic [WIDTH*HEIGHT-1:0]   grid_init_o,
    output logic                      grid_step_o,
    input  logic [WIDTH*HEIGHT-1:0]   grid_states_i,
    output logic                      pix_valid_o,
    input  logic                      pix_ready_i,
    output logic                      pix_data_o,
    output logic [4:0]                pix_row_o,
    output logic [4:0]                pix_col_o,
    output logic                      pix_eol_o,
    output logic                      pix_eof_o,
    output logic                      busy_o,
    output logic [15:0]               gen_count_o
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int IDX_W = $clog2(CELLS);
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CELLS - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [4:0]       LAST_COL    = 5'(WIDTH - 1);
    localparam logic [4:0]       LAST_ROW    = 5'(HEIGHT - 1);

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_RUN  = 2'd2;
    localparam logic [1:0] OP_SCAN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COMMIT = 3'd2,
        S_STEP   = 3'd3,
        S_SETTLE = 3'd4,
        S_SCAN   = 3'd5
    } state_t;

    state_t             state_q,    state_d;
    logic [1:0]         op_q,       op_d;
    logic [15:0]        remain_q,   remain_d;
    logic [SET_W-1:0]   settle_q,   settle_d;
    logic [CELLS-1:0]   init_q,     init_d;
    logic [IDX_W-1:0]   load_idx_q, load_idx_d;
    logic [15:0]        gen_q,      gen_d;
    logic [CELLS-1:0]   frame_q,    frame_d;
    logic [IDX_W-1:0]   pix_idx_q,  pix_idx_d;
    logic [4:0]         row_q,      row_d;
    logic [4:0]         col_q,      col_d;

    logic               w_eol;
    logic               w_eof;

    assign w_eol = (col_q == LAST_COL);
    assign w_eof = w_eol && (row_q == LAST_ROW);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_LOAD;
            remain_q   <= '0;
            settle_q   <= '0;
            init_q     <= '0;
            load_idx_q <= '0;
            gen_q      <= '0;
            frame_q    <= '0;
            pix_idx_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            remain_q   <= remain_d;
            settle_q   <= settle_d;
            init_q     <= init_d;
            load_idx_q <= load_idx_d;
            gen_q      <= gen_d;
            frame_q    <= frame_d;
            pix_idx_q  <= pix_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        remain_d     = remain_q;
        settle_d     = settle_q;
        init_d       = init_q;
        load_idx_d   = load_idx_q;
        gen_d        = gen_q;
        frame_d      = frame_q;
        pix_idx_d    = pix_idx_q;
        row_d        = row_q;
        col_d        = col_q;
        cmd_ready_o  = 1'b0;
        load_ready_o = 1'b0;
        grid_load_o  = 1'b0;
        grid_step_o  = 1'b0;
        pix_valid_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    op_d     = cmd_op_i;
                    remain_d = cmd_arg_i;
                    settle_d = '0;
                    case (cmd_op_i)
                        OP_LOAD: begin
                            state_d    = S_LOAD;
                            load_idx_d = '0;
                        end
                        OP_STEP, OP_RUN: begin
                            if (cmd_arg_i != 16'd0) state_d = S_STEP;
                        end
                        default: state_d = S_SETTLE;
                    endcase
                end
            end
            S_LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    init_d[load_idx_q] = load_bit_i;
                    if (load_idx_q == LAST_IDX) state_d = S_COMMIT;
                    else                        load_idx_d = load_idx_q + 1'b1;
                end
            end
            S_COMMIT: begin
                grid_load_o = 1'b1;
                gen_d       = '0;
                settle_d    = '0;
                state_d     = S_SETTLE;
            end
            S_STEP: begin
                grid_step_o = 1'b1;
                gen_d       = gen_q + 16'd1;
                remain_d    = remain_q - 16'd1;
                settle_d    = '0;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    case (op_q)
                        OP_LOAD: state_d = S_IDLE;
                        OP_STEP: state_d = (remain_q != 16'd0) ? S_STEP : S_IDLE;
                        default: begin
                            // Frame is frozen here so later grid steps cannot tear it.
                            state_d   = S_SCAN;
                            frame_d   = grid_states_i;
                            pix_idx_d = '0;
                            row_d     = '0;
                            col_d     = '0;
                        end
                    endcase
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SCAN: begin
                pix_valid_o = 1'b1;
                if (pix_ready_i) begin
                    if (w_eof) begin
                        state_d = (op_q == OP_RUN && remain_q != 16'd0) ? S_STEP : S_IDLE;
                    end else begin
                        pix_idx_d = pix_idx_q + 1'b1;
                        if (w_eol) begin
                            col_d = '0;
                            row_d = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign grid_init_o = init_q;
    assign pix_data_o  = frame_q[pix_idx_q];
    assign pix_row_o   = row_q;
    assign pix_col_o   = col_q;
    assign pix_eol_o   = w_eol;
    assign pix_eof_o   = w_eof;
    assign busy_o      = (state_q != S_IDLE);
    assign gen_count_o = gen_q;

endmodule
`default_nettype wire

// File: tb/tb_life_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_sequencer
// Purpose  : Scoreboard bench for life_sequencer with a behavioural Life grid.
// Revision : 1.0
// ============================================================================
module tb_life_sequencer;

    localparam int W = 17;
    localparam int H = 17;
    localparam int N = W * H;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'd0;
    logic [15:0]    cmd_arg = 16'd0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic           load_bit = 1'b0;
    logic           grid_load;
    logic [N-1:0]   grid_init;
    logic           grid_step;
    logic [N-1:0]   grid = '0;
    logic           pix_valid;
    logic           pix_ready = 1'b1;
    logic           pix_data;
    logic [4:0]     pix_row;
    logic [4:0]     pix_col;
    logic           pix_eol;
    logic           pix_eof;
    logic           busy;
    logic [15:0]    gen_count;

    typedef struct packed {
        logic       d;
        logic [4:0] r;
        logic [4:0] c;
        logic       eol;
        logic       eof;
    } pix_t;

    pix_t   exp_q[$];
    int     step_t[$];
    int     checks = 0;
    int     fails = 0;
    int     cyc = 0;
    int     load_cnt = 0;
    int     step_cnt = 0;
    bit     ready_mode = 1'b0;
    logic [N-1:0] fh;
    logic [N-1:0] fv;
    logic [N-1:0] ones;

    life_sequencer #(.WIDTH(W), .HEIGHT(H), .SETTLE(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_arg_i     (cmd_arg),
        .load_valid_i  (load_valid),
        .load_ready_o  (load_ready),
        .load_bit_i    (load_bit),
        .grid_load_o   (grid_load),
        .grid_init_o   (grid_init),
        .grid_step_o   (grid_step),
        .grid_states_i (grid),
        .pix_valid_o   (pix_valid),
        .pix_ready_i   (pix_ready),
        .pix_data_o    (pix_data),
        .pix_row_o     (pix_row),
        .pix_col_o     (pix_col),
        .pix_eol_o     (pix_eol),
        .pix_eof_o     (pix_eof),
        .busy_o        (busy),
        .gen_count_o   (gen_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
        logic [N-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[((r + dr + H) % H) * W + (c + dc + W) % W]);
                n[r*W+c] = (cnt == 3) || (cnt == 2 && g[r*W+c]);
            end
        end
        return n;
    endfunction

    // Toroidal cell array driven only by the sequencer's strobes.
    always @(posedge clock) begin
        if (grid_load)      grid <= grid_init;
        else if (grid_step) grid <= life_next(grid);
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [N-1:0] f);
        pix_t p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p.d   = f[r*W+c];
                p.r   = 5'(r);
                p.c   = 5'(c);
                p.eol = (c == W - 1);
                p.eof = (c == W - 1) && (r == H - 1);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        @(negedge clock);
        chk("cmd_ready_at_issue", N'(cmd_ready), N'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk("idle_within_budget", N'(busy), N'(0));
        tick();
    endtask

    task automatic load_pattern(input logic [N-1:0] pat, input int nbits);
        int k;
        for (int i = 0; i < nbits; i++) begin
            if (i % 64 == 63) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_bit   = pat[i];
            @(negedge clock);
            k = 0;
            while (!load_ready && k < 10) begin
                @(negedge clock);
                k++;
            end
            if (!load_ready) begin
                chk("load_ready_timeout", N'(load_ready), N'(1));
                load_valid = 1'b0;
                return;
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            pix_ready = ready_mode ? ~pix_ready : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (grid_load) load_cnt++;
            if (grid_step) begin
                step_cnt++;
                step_t.push_back(cyc);
            end
        end
    end

    // Pixel monitor: scoreboard pop on every handshake, hold check on every stall.
    initial begin
        pix_t cur;
        pix_t prev;
        bit   stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clock);
            cur = '{d: pix_data, r: pix_row, c: pix_col, eol: pix_eol, eof: pix_eof};
            if (stalled) begin
                chk("pix_valid_hold", N'(pix_valid), N'(1));
                chk("pix_fields_hold", N'(cur), N'(prev));
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL pix_extra: got pixel r=%0d c=%0d, required none", pix_row, pix_col);
                end else begin
                    chk("pix", N'(cur), N'(exp_q.pop_front()));
                end
            end
            stalled = pix_valid && !pix_ready;
            prev    = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int t0;
        int lc;
        fh = '0;
        fh[0] = 1'b1; fh[1] = 1'b1; fh[2] = 1'b1;
        fv = '0;
        fv[273] = 1'b1; fv[1] = 1'b1; fv[18] = 1'b1;
        ones = '1;

        // Reset state
        tick(); tick();
        @(negedge clock);
        chk("rst_cmd_ready", N'(cmd_ready), N'(1));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_load_ready", N'(load_ready), N'(0));
        chk("rst_pix_valid", N'(pix_valid), N'(0));
        chk("rst_strobes", N'({grid_load, grid_step}), N'(0));
        chk("rst_grid_init", grid_init, '0);
        chk("rst_gen_count", N'(gen_count), N'(0));
        tick();
        reset = 1'b0;
        tick();

        // Load blinker on row 0
        send_cmd(2'd0, 16'd0);
        load_pattern(fh, N);
        wait_idle(20);
        chk("load_pulses", N'(load_cnt), N'(1));
        chk("grid_init", grid_init, fh);
        chk("gen_after_load", N'(gen_count), N'(0));

        // Full-rate scan
        push_frame(fh);
        send_cmd(2'd3, 16'd0);
        wait_idle(400);
        chk("scan1_drained", N'(exp_q.size()), N'(0));

        // STEP 2 while a competing command is offered
        s0 = step_cnt;
        t0 = step_t.size();
        send_cmd(2'd1, 16'd2);
        cmd_op    = 2'd1;
        cmd_arg   = 16'd7;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("cmd_ready_busy", N'(cmd_ready), N'(0));
            tick();
        end
        cmd_valid = 1'b0;
        wait_idle(50);
        chk("step2_pulses", N'(step_cnt - s0), N'(2));
        if (step_t.size() >= t0 + 2)
            chk("step2_spacing", N'(step_t[t0+1] - step_t[t0]), N'(3));
        chk("gen_after_step2", N'(gen_count), N'(2));
        push_frame(fh);
        send_cmd(2'd3, 16'd0);
        wait_idle(400);
        chk("scan2_drained", N'(exp_q.size()), N'(0));

        // RUN 3 with pix_ready toggling
        send_cmd(2'd0, 16'd0);
        load_pattern(fh, N);
        wait_idle(20);
        chk("gen_after_reload", N'(gen_count), N'(0));
        s0 = step_cnt;
        push_frame(fv);
        push_frame(fh);
        push_frame(fv);
        ready_mode = 1'b1;
        send_cmd(2'd2, 16'd3);
        wait_idle(3000);
        ready_mode = 1'b0;
        chk("run_drained", N'(exp_q.size()), N'(0));
        chk("run_pulses", N'(step_cnt - s0), N'(3));
        chk("gen_after_run", N'(gen_count), N'(3));

        // STEP 0 is a no-op
        s0 = step_cnt;
        send_cmd(2'd1, 16'd0);
        @(negedge clock);
        chk("step0_ready", N'(cmd_ready), N'(1));
        chk("step0_busy", N'(busy), N'(0));
        tick();
        repeat (4) tick();
        chk("step0_pulses", N'(step_cnt - s0), N'(0));

        // Reset in the middle of a load
        lc = load_cnt;
        send_cmd(2'd0, 16'd0);
        load_pattern(ones, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_grid_init", grid_init, '0);
        chk("midrst_busy", N'(busy), N'(0));
        chk("midrst_cmd_ready", N'(cmd_ready), N'(1));
        chk("midrst_load_ready", N'(load_ready), N'(0));
        chk("midrst_gen", N'(gen_count), N'(0));
        tick();
        repeat (5) tick();
        chk("midrst_no_load", N'(load_cnt - lc), N'(0));

        // gen_count wrap
        @(negedge clock);
        force dut.gen_q = 16'hFFFF;
        @(posedge clock);
        @(negedge clock);
        release dut.gen_q;
        tick();
        send_cmd(2'd1, 16'd1);
        wait_idle(20);
        chk("gen_wrap", N'(gen_count), N'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
